// File: rtl/r16_frame_unloader.sv
// r16_frame_unloader
//
// Purpose: downstream end of the radix-16 butterfly datapath. A complete
// 16-point complex frame is captured in one cycle into one of two ping-pong
// frame buffers. Frames leave one complex sample per cycle in natural bin
// order 0..15 over a valid/ready stream. Two buffers let the butterfly hand
// over the next frame while the current one drains.
//
// Ports:
//   clk        rising-edge clock for all state
//   reset      synchronous, active-high reset
//   in_valid   frame present on in_r/in_i
//   in_ready   a free buffer exists; capture on in_valid && in_ready
//   in_r/in_i  16 x 32-bit real/imaginary parts, index k = bin k
//   out_valid  out_r/out_i/out_idx hold a valid sample
//   out_ready  consumer accepts; transfer on out_valid && out_ready
//   out_r/out_i 32-bit real/imaginary parts of the current sample
//   out_idx    bin index of the current sample
//   out_last   high on bin 15
//
// Optional build macro: R16_UNLOAD_SCALE_EN
//   Defined   : every output word is scaled by 1/16 through an exponent
//               adjustment on the read path (denormals flush to signed zero,
//               Inf/NaN pass unchanged). Latency is unchanged.
//   Undefined : words pass bit-exact and no scaling logic exists.

module r16_frame_unloader #(
  parameter int DW = 32,  // IEEE-754 single precision only
  parameter int N  = 16   // points per frame
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [N-1:0][DW-1:0] in_r,
  input  logic [N-1:0][DW-1:0] in_i,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [DW-1:0]        out_r,
  output logic [DW-1:0]        out_i,
  output logic [3:0]           out_idx,
  output logic                 out_last
);

  localparam int IW = 4;
  localparam logic [IW-1:0] IDX_LAST = IW'(N - 1);
  localparam logic [IW-1:0] IDX_ONE  = IW'(1);

  // Occupancy doubles as the FSM state.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } occ_t;

  occ_t          occ_q, occ_d;
  logic          wr_sel_q, wr_sel_d;
  logic          rd_sel_q, rd_sel_d;
  logic [IW-1:0] rd_idx_q, rd_idx_d;

  // Ping-pong frame storage, indexed [bank][bin]. Contents are never reset;
  // occupancy alone decides what is valid.
  logic [DW-1:0] buf_r_q [2][N];
  logic [DW-1:0] buf_i_q [2][N];

  logic          capture;
  logic          pop;
  logic          frame_done;
  logic [DW-1:0] raw_r;
  logic [DW-1:0] raw_i;

  // ---------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      occ_q    <= EMPTY;
      wr_sel_q <= 1'b0;
      rd_sel_q <= 1'b0;
      rd_idx_q <= '0;
    end else begin
      occ_q    <= occ_d;
      wr_sel_q <= wr_sel_d;
      rd_sel_q <= rd_sel_d;
      rd_idx_q <= rd_idx_d;
    end
  end

  // Whole-frame write into the bank selected by wr_sel.
  always_ff @(posedge clk) begin
    if (capture) begin
      for (int k = 0; k < N; k++) begin
        buf_r_q[wr_sel_q][k] <= in_r[k];
        buf_i_q[wr_sel_q][k] <= in_i[k];
      end
    end
  end

  // ---------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------
  always_comb begin
    occ_d    = occ_q;
    wr_sel_d = wr_sel_q;
    rd_sel_d = rd_sel_q;
    rd_idx_d = rd_idx_q;

    if (capture) begin
      wr_sel_d = ~wr_sel_q;
    end

    if (pop) begin
      rd_idx_d = rd_idx_q + IDX_ONE;  // 15 wraps to 0
      if (frame_done) begin
        rd_sel_d = ~rd_sel_q;
      end
    end

    // A capture and a frame release in the same cycle cancel out.
    unique case (occ_q)
      EMPTY: begin
        if (capture) occ_d = ONE;
      end
      ONE: begin
        if (capture && !frame_done)      occ_d = FULL;
        else if (!capture && frame_done) occ_d = EMPTY;
      end
      FULL: begin
        // in_ready is low here, so only a release can happen.
        if (frame_done) occ_d = ONE;
      end
      default: occ_d = EMPTY;
    endcase
  end

  // ---------------------------------------------------------------------
  // Output logic
  // ---------------------------------------------------------------------
  always_comb begin
    // Handshakes depend on registered occupancy only: no out_ready -> in_ready
    // path, so a FULL buffer frees up one cycle after its last pop.
    in_ready   = (occ_q != FULL) && !reset;
    out_valid  = (occ_q != EMPTY) && !reset;
    capture    = in_valid && in_ready;
    pop        = out_valid && out_ready;
    frame_done = pop && (rd_idx_q == IDX_LAST);
    out_idx    = rd_idx_q;
    out_last   = (rd_idx_q == IDX_LAST);
    raw_r      = buf_r_q[rd_sel_q][rd_idx_q];
    raw_i      = buf_i_q[rd_sel_q][rd_idx_q];
  end

`ifdef R16_UNLOAD_SCALE_EN
  // Divide by 16 by lowering the exponent by 4. Results that would become
  // denormal flush to a signed zero; Inf/NaN keep their encoding.
  function automatic logic [DW-1:0] scale_by_16(input logic [DW-1:0] w);
    logic [7:0] e;
    e = w[30:23];
    if (e == 8'hFF) begin
      scale_by_16 = w;
    end else if (e < 8'd5) begin
      scale_by_16 = {w[31], 31'b0};
    end else begin
      scale_by_16 = {w[31], e - 8'd4, w[22:0]};
    end
  endfunction

  assign out_r = scale_by_16(raw_r);
  assign out_i = scale_by_16(raw_i);
`else
  assign out_r = raw_r;
  assign out_i = raw_i;
`endif

endmodule

// File: tb/tb_r16_frame_unloader.sv
// Directed testbench for r16_frame_unloader. Each task drives one scenario
// and compares DUT outputs against hand-derived expected values.

module tb_r16_frame_unloader;

  logic              clk = 1'b0;
  logic              reset;
  logic              in_valid;
  logic              in_ready;
  logic [15:0][31:0] in_r;
  logic [15:0][31:0] in_i;
  logic              out_valid;
  logic              out_ready;
  logic [31:0]       out_r;
  logic [31:0]       out_i;
  logic [3:0]        out_idx;
  logic              out_last;

  int checks = 0;
  int errors = 0;

  // {valid, idx, last, r, i}
  logic [69:0] act;
  assign act = {out_valid, out_idx, out_last, out_r, out_i};

  // in_r[k] = k as float
  logic [31:0] flt_tab [16] = '{
    32'h00000000, 32'h3F800000, 32'h40000000, 32'h40400000,
    32'h40800000, 32'h40A00000, 32'h40C00000, 32'h40E00000,
    32'h41000000, 32'h41100000, 32'h41200000, 32'h41300000,
    32'h41400000, 32'h41500000, 32'h41600000, 32'h41700000
  };

  r16_frame_unloader dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_r      (in_r),
    .in_i      (in_i),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_r     (out_r),
    .out_i     (out_i),
    .out_idx   (out_idx),
    .out_last  (out_last)
  );

  always #5 clk = ~clk;

  // One line per transaction.
  always @(posedge clk) begin
    if (!reset && in_valid && in_ready)
      $display("capture r0=%h r15=%h", in_r[0], in_r[15]);
    if (!reset && out_valid && out_ready)
      $display("pop idx=%0d r=%h i=%h last=%b", out_idx, out_r, out_i, out_last);
  end

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

  // Expected value of a word leaving the DUT.
  function automatic logic [31:0] exp_word(input logic [31:0] w);
`ifdef R16_UNLOAD_SCALE_EN
    if (w[30:23] == 8'hFF) return w;
    if (w[30:23] < 8'd5) return {w[31], 31'b0};
    return {w[31], w[30:23] - 8'd4, w[22:0]};
`else
    return w;
`endif
  endfunction

  function automatic logic [31:0] gen_r(input int f, input int k);
    return 32'h4000_0000 | (32'(f) << 8) | 32'(k);
  endfunction

  function automatic logic [31:0] gen_i(input int f, input int k);
    return 32'hC000_0000 | (32'(f) << 8) | 32'(k);
  endfunction

  function automatic logic [69:0] exp_sample(input logic [31:0] r, input logic [31:0] i, input int k);
    return {1'b1, 4'(k), (k == 15), exp_word(r), exp_word(i)};
  endfunction

  function automatic logic [69:0] exp_frame(input int f, input int k);
    return exp_sample(gen_r(f, k), gen_i(f, k), k);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_frame(input int f);
    for (int k = 0; k < 16; k++) begin
      in_r[k] = gen_r(f, k);
      in_i[k] = gen_i(f, k);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
    load_frame(99);
    for (int c = 0; c < 3; c++) begin
      tick();
      checks++;
      if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready: got %b expected 0", in_ready); end
      checks++;
      if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
    end
    reset = 1'b0; in_valid = 1'b0;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL post_reset_in_ready: got %b expected 1", in_ready); end
    tick();
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL post_reset_out_valid: got %b expected 0", out_valid); end
  endtask

  task automatic test_single_frame();
    out_ready = 1'b1;
    for (int k = 0; k < 16; k++) begin
      in_r[k] = flt_tab[k];
      in_i[k] = 32'hBF800000;
    end
    in_valid = 1'b1;
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL single_in_ready: got %b expected 1", in_ready); end
    tick();
    in_valid = 1'b0;
    for (int k = 0; k < 16; k++) begin
      checks++;
      if (act !== exp_sample(flt_tab[k], 32'hBF800000, k)) begin
        errors++;
        $display("FAIL single_sample k=%0d: got %h expected %h", k, act, exp_sample(flt_tab[k], 32'hBF800000, k));
      end
      tick();
    end
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL single_drained: out_valid got %b expected 0", out_valid); end
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL single_in_ready_end: got %b expected 1", in_ready); end
  endtask

  task automatic test_back_to_back();
    int sent = 0;
    int recv = 0;
    out_ready = 1'b1;
    for (int cyc = 0; cyc < 34; cyc++) begin
      in_valid = (sent < 2);
      if (sent < 2) begin
        load_frame(1 + sent);
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL b2b_in_ready cyc=%0d: got %b expected 1", cyc, in_ready); end
      end
      checks++;
      if (out_valid !== (cyc >= 1 && cyc <= 32)) begin
        errors++; $display("FAIL b2b_valid cyc=%0d: got %b expected %b", cyc, out_valid, (cyc >= 1 && cyc <= 32));
      end
      if (out_valid) begin
        checks++;
        if (act !== exp_frame(1 + recv / 16, recv % 16)) begin
          errors++; $display("FAIL b2b_sample n=%0d: got %h expected %h", recv, act, exp_frame(1 + recv / 16, recv % 16));
        end
        recv++;
      end
      if (in_valid && in_ready) sent++;
      tick();
    end
    in_valid = 1'b0;
  endtask

  // One frame every 16 cycles: capture and final pop coincide while ONE.
  task automatic test_steady_stream();
    int recv = 0;
    out_ready = 1'b1;
    for (int cyc = 0; cyc < 50; cyc++) begin
      in_valid = (cyc % 16 == 0) && (cyc <= 32);
      load_frame(30 + cyc / 16);
      if (in_valid) begin
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL steady_in_ready cyc=%0d: got %b expected 1", cyc, in_ready); end
      end
      checks++;
      if (out_valid !== (cyc >= 1 && cyc <= 48)) begin
        errors++; $display("FAIL steady_valid cyc=%0d: got %b expected %b", cyc, out_valid, (cyc >= 1 && cyc <= 48));
      end
      if (out_valid) begin
        checks++;
        if (act !== exp_frame(30 + recv / 16, recv % 16)) begin
          errors++; $display("FAIL steady_sample n=%0d: got %h expected %h", recv, act, exp_frame(30 + recv / 16, recv % 16));
        end
        recv++;
      end
      tick();
    end
    in_valid = 1'b0;
  endtask

  task automatic test_backpressure();
    int recv = 0;
    int cyc;
    int f;
    bit c_sent = 0;
    out_ready = 1'b0;
    for (int c = 0; c < 2; c++) begin
      load_frame(3 + c);
      in_valid = 1'b1;
      checks++;
      if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_in_ready_accept c=%0d: got %b expected 1", c, in_ready); end
      tick();
    end
    load_frame(5);
    for (int c = 2; c < 5; c++) begin
      checks++;
      if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready_full c=%0d: got %b expected 0", c, in_ready); end
      checks++;
      if (act !== exp_frame(3, 0)) begin errors++; $display("FAIL bp_hold c=%0d: got %h expected %h", c, act, exp_frame(3, 0)); end
      tick();
    end
    out_ready = 1'b1;
    cyc = 5;
    while (recv < 48 && cyc < 120) begin
      in_valid = !c_sent;
      if (!c_sent) begin
        checks++;
        if (in_ready !== (cyc == 21)) begin
          errors++; $display("FAIL bp_in_ready cyc=%0d: got %b expected %b", cyc, in_ready, (cyc == 21));
        end
      end
      f = (recv < 16) ? 3 : (recv < 32) ? 4 : 5;
      checks++;
      if (act !== exp_frame(f, recv % 16)) begin
        errors++; $display("FAIL bp_sample n=%0d: got %h expected %h", recv, act, exp_frame(f, recv % 16));
      end
      if (out_valid) recv++;
      if (in_valid && in_ready) c_sent = 1;
      tick();
      cyc++;
    end
    in_valid = 1'b0;
    checks++;
    if (recv != 48) begin errors++; $display("FAIL bp_count: got %0d expected 48", recv); end
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_drained: out_valid got %b expected 0", out_valid); end
  endtask

  task automatic test_random_stall();
    int sent = 0;
    int recv = 0;
    int cyc = 0;
    while (recv < 128 && cyc < 2000) begin
      in_valid = (sent < 8);
      if (sent < 8) load_frame(10 + sent);
      out_ready = 1'($urandom_range(0, 1));
      if (out_valid && out_ready) begin
        checks++;
        if (act !== exp_frame(10 + recv / 16, recv % 16)) begin
          errors++; $display("FAIL rand_sample n=%0d: got %h expected %h", recv, act, exp_frame(10 + recv / 16, recv % 16));
        end
        recv++;
      end
      if (in_valid && in_ready) sent++;
      tick();
      cyc++;
    end
    in_valid = 1'b0;
    checks++;
    if (recv != 128) begin errors++; $display("FAIL rand_count: got %0d expected 128", recv); end
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL rand_drained: out_valid got %b expected 0", out_valid); end
  endtask

  task automatic test_reset_mid_frame();
    out_ready = 1'b1;
    load_frame(20); in_valid = 1'b1;
    tick();
    load_frame(21);
    tick();
    in_valid = 1'b0;
    repeat (6) tick();
    checks++;
    if (act !== exp_frame(20, 7)) begin errors++; $display("FAIL mid_a7: got %h expected %h", act, exp_frame(20, 7)); end
    reset = 1'b1;
    for (int c = 0; c < 2; c++) begin
      #1;
      checks++;
      if (out_valid !== 1'b0) begin errors++; $display("FAIL mid_reset_valid c=%0d: got %b expected 0", c, out_valid); end
      checks++;
      if (in_ready !== 1'b0) begin errors++; $display("FAIL mid_reset_ready c=%0d: got %b expected 0", c, in_ready); end
      tick();
    end
    reset = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL mid_after_valid: got %b expected 0", out_valid); end
    load_frame(22); in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    for (int k = 0; k < 16; k++) begin
      checks++;
      if (act !== exp_frame(22, k)) begin errors++; $display("FAIL mid_c k=%0d: got %h expected %h", k, act, exp_frame(22, k)); end
      tick();
    end
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL mid_no_b: out_valid got %b expected 0", out_valid); end
  endtask

`ifdef R16_UNLOAD_SCALE_EN
  task automatic test_scale();
    logic [31:0] vin  [5] = '{32'h3F800000, 32'hC1800000, 32'h02000000, 32'h80000001, 32'h7FC00000};
    logic [31:0] vexp [5] = '{32'h3D800000, 32'hBF800000, 32'h00000000, 32'h80000000, 32'h7FC00000};
    out_ready = 1'b1;
    in_r = '0; in_i = '0;
    for (int k = 0; k < 5; k++) in_r[k] = vin[k];
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    for (int k = 0; k < 16; k++) begin
      if (k < 5) begin
        checks++;
        if (out_r !== vexp[k]) begin errors++; $display("FAIL scale k=%0d: got %h expected %h", k, out_r, vexp[k]); end
      end
      tick();
    end
  endtask
`endif

  initial begin
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    in_r = '0; in_i = '0;
    test_reset();
    test_single_frame();
    test_back_to_back();
    test_steady_stream();
    test_backpressure();
    test_random_stall();
    test_reset_mid_frame();
`ifdef R16_UNLOAD_SCALE_EN
    test_scale();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/r16_frame_unloader.md
Name: r16_frame_unloader

Overview:
- Downstream end of the radix-16 butterfly datapath.
- Accepts one complete 16-point complex result frame (16 real + 16 imaginary single-precision floats) in a single cycle from the parallel butterfly output.
- Streams the frame out one complex sample per cycle, in natural index order 0..15, over a valid/ready interface.
- Double-buffered (ping-pong) so the butterfly can deliver the next frame while the current one drains.

Parameters:
- DW, 32, float word width; the block supports only IEEE-754 single precision, so DW=32 is fixed.
- N, 16, points per frame; fixed at 16, which sets the 4-bit index width.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- in_valid  input  1  frame present on in_r/in_i.
- in_ready  output  1  a free buffer exists; the frame is captured when in_valid && in_ready.
- in_r  input  16x32  real parts of the frame, index k = frequency bin k.
- in_i  input  16x32  imaginary parts of the frame.
- out_valid  output  1  out_r/out_i/out_idx hold a valid sample.
- out_ready  input  1  consumer accepts the sample; a transfer occurs when out_valid && out_ready.
- out_r  output  32  real part of the current sample.
- out_i  output  32  imaginary part of the current sample.
- out_idx  output  4  bin index of the current sample.
- out_last  output  1  high when out_idx==15.

Behaviour:
- Storage: two frame buffers, buf0 and buf1, each 16x(32+32) bits.
- Pointers: wr_sel and rd_sel (1 bit each), a 4-bit read index rd_idx, and a 2-bit occupancy count occ in {0,1,2}. State names: EMPTY (occ=0), ONE (occ=1), FULL (occ=2).
- Reset, on the clk edge with reset high: occ=0, wr_sel=0, rd_sel=0, rd_idx=0. While reset is high, in_ready=0 and out_valid=0. Buffer contents are not reset; out_r, out_i and out_idx are don't-care while out_valid=0.
- in_ready = (occ!=2) && !reset. It is a function of registered state only, with no combinational path from out_ready.
- Capture (in_valid && in_ready): all 32 words written into buf[wr_sel]; wr_sel toggles.
- out_valid = (occ!=0) && !reset.
- Output data: out_r/out_i = buf[rd_sel][rd_idx]; out_idx = rd_idx. These are driven from registered storage only.
- Pop (out_valid && out_ready):
  - rd_idx increments, wrapping 15 -> 0.
  - When rd_idx==15, rd_sel toggles and the frame is released.
- Occupancy update:
  - Capture without a frame release: occ+1.
  - Frame release without a capture: occ-1.
  - Capture and frame release in the same cycle: occ unchanged.
- Latency: a frame captured at edge T gives out_valid=1 with idx 0 in the cycle after T, provided occ was 0 before T.
- Throughput: one sample per cycle with out_ready held high. A steady stream of one frame every 16 cycles sustains 100% output utilisation with no gaps.
- Boundary conditions:
  - FULL and final pop in the same cycle: in_ready was 0 that cycle, so no capture. in_ready rises the next cycle.
  - ONE with a capture and the final pop in the same cycle: occ stays 1, and the next frame's idx 0 appears the following cycle with no bubble.
  - out_ready low: sample, index and out_last held stable; rd_idx frozen.
  - in_valid with in_ready=0: frame ignored, no state change. The producer holds the frame.
  - Reset mid-frame: the partially drained frame and any queued frame are discarded. The first frame after reset starts at idx 0 from buf0.

Optional Feature:
- Macro: R16_UNLOAD_SCALE_EN.
- Defined: each output word is scaled by 1/16 via an exponent adjustment applied on the read path. Latency is unchanged. For exponent field e:
  - e in 5..254: e-4.
  - e in 0..4: result is a signed zero (sign kept, exponent and mantissa 0), i.e. denormals are flushed.
  - e==255 (Inf/NaN): passed unchanged.
- Not defined: words are passed bit-exact. No scaling logic is synthesised.

Test Plan:
- Reset then single frame, in_r[k]=k as float (0x00000000, 0x3F800000, 0x40000000, ...), in_i[k]=0xBF800000, out_ready=1:
  - out_valid rises the cycle after capture.
  - 16 consecutive samples with out_idx 0..15, out_r matching in_r[k] bit-exact.
  - out_last only at idx 15.
  - occ returns to 0 and out_valid falls after the 16th sample.
- Back-to-back frames A then B, out_ready=1, in_valid held:
  - B captured while A drains; in_ready stays high.
  - 32 contiguous samples, A0..A15 then B0..B15, with no bubble.
- out_ready=0 with three frames offered:
  - First two captured; in_ready=0 after the second.
  - Third held by the producer.
  - Releasing out_ready: in_ready rises the cycle after A's idx-15 pop; the third frame then follows B in order.
- Random out_ready stall pattern (~50%) over 8 frames: output sequence identical to the input frames in order, with no duplicates or drops.
- Reset asserted at A idx 7 with B queued:
  - out_valid=0 and in_ready=0 during reset.
  - After reset, a new frame C streams from idx 0; no A or B data appears.
- With R16_UNLOAD_SCALE_EN:
  - 0x3F800000 -> 0x3D800000.
  - 0xC1800000 -> 0xBF800000.
  - 0x02000000 (e=4) -> 0x00000000.
  - 0x80000001 -> 0x80000000.
  - 0x7FC00000 -> 0x7FC00000.
